// File: rtl/hazard_pkg.sv
// Shared encodings, scoreboard stage layouts and hazard helper functions
// for hazard_ctrl. Forwarding is enabled with the HAZARD_FWD_EN macro.
package hazard_pkg;

  typedef logic [4:0] reg_t;

  // Stage at which a consumer first needs its source operand
  typedef enum logic [1:0] {
    TUSE_D    = 2'd0,
    TUSE_E    = 2'd1,
    TUSE_M    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  // Cycles until a producer's result exists, counted at E entry
  typedef enum logic [1:0] {
    TNEW_LINK = 2'd0,
    TNEW_ALU  = 2'd1,
    TNEW_LOAD = 2'd2
  } tnew_e;

  // D-stage compare operand selects
  typedef enum logic [1:0] {
    SEL_REG = 2'd0,
    SEL_E   = 2'd1,
    SEL_M   = 2'd2,
    SEL_W   = 2'd3
  } sel_e;

  // E-stage ALU operand selects
  localparam logic [1:0] ESEL_REG = 2'd0;
  localparam logic [1:0] ESEL_M   = 2'd1;
  localparam logic [1:0] ESEL_W   = 2'd2;

  typedef struct packed {
    reg_t       wa;
    logic [1:0] tnew;
    reg_t       rs;
    reg_t       rt;
  } e_stage_t;

  typedef struct packed {
    reg_t       wa;
    logic [1:0] tnew;
    reg_t       rt;
  } m_stage_t;

  typedef struct packed {
    reg_t wa;
  } w_stage_t;

  // $0 is hard-wired, so it never matches anything
  function automatic logic hit(reg_t src, reg_t wa);
    return (src != '0) && (src == wa);
  endfunction

  // One cycle closer to the result, floored at 0
  function automatic logic [1:0] tnew_dec(logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // Consumer must wait: a producer in E/M won't have the value in time
  function automatic logic fwd_stall(reg_t src, logic [1:0] tuse,
                                     e_stage_t e, m_stage_t m);
    return (tuse != TUSE_NONE) &&
           ((hit(src, e.wa) && (tuse < e.tnew)) ||
            (hit(src, m.wa) && (tuse < m.tnew)));
  endfunction

  // Without bypass paths any in-flight writer of the source blocks D
  function automatic logic blind_stall(reg_t src, logic [1:0] tuse,
                                       e_stage_t e, m_stage_t m, w_stage_t w);
    return (tuse != TUSE_NONE) &&
           (hit(src, e.wa) || hit(src, m.wa) || hit(src, w.wa));
  endfunction

  // Youngest ready producer wins for the D compare operands
  function automatic logic [1:0] d_sel(reg_t src, e_stage_t e, m_stage_t m,
                                       w_stage_t w);
    if (hit(src, e.wa) && (e.tnew == TNEW_LINK)) return SEL_E;
    if (hit(src, m.wa) && (m.tnew == TNEW_LINK)) return SEL_M;
    if (hit(src, w.wa))                          return SEL_W;
    return SEL_REG;
  endfunction

  function automatic logic [1:0] e_sel(reg_t src, m_stage_t m, w_stage_t w);
    if (hit(src, m.wa) && (m.tnew == TNEW_LINK)) return ESEL_M;
    if (hit(src, w.wa))                          return ESEL_W;
    return ESEL_REG;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One scoreboard stage: loads its input each cycle, or an all-zero bubble;
// synchronous active-high clear.
module hazard_stage_reg
  import hazard_pkg::*;
#(
  parameter type T = e_stage_t
) (
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  T     d,
  output T     q
);

  T stage_d, stage_q;

  // Bubble replaces the incoming instruction with an empty slot
  always_comb begin
    stage_d = d;
    if (bubble) stage_d = '0;
  end

  // Stage register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: E/M/W destination scoreboard, stall and
// operand-forwarding selects, stalled-cycle counter.
// `define HAZARD_FWD_EN to enable forwarding; otherwise any pending
// writer of a used source stalls D and all selects are 0.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic [4:0]  D_wa,
  input  logic [1:0]  D_tnew,
  output logic        stall,
  output logic [1:0]  D_rs_sel,
  output logic [1:0]  D_rt_sel,
  output logic [1:0]  E_rs_sel,
  output logic [1:0]  E_rt_sel,
  output logic        M_rt_sel,
  output logic [31:0] stall_cnt
);

  e_stage_t    e_d, e_q;
  m_stage_t    m_d, m_q;
  w_stage_t    w_d, w_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Next contents of each stage; tnew counts down as the producer moves on
  always_comb begin
    e_d = '{wa: D_wa, tnew: D_tnew, rs: D_rs, rt: D_rt};
    m_d = '{wa: e_q.wa, tnew: tnew_dec(e_q.tnew), rt: e_q.rt};
    w_d = '{wa: m_q.wa};
  end

  hazard_stage_reg #(.T(e_stage_t)) u_stage_e (
    .clk(clk), .reset(reset), .bubble(stall), .d(e_d), .q(e_q)
  );
  hazard_stage_reg #(.T(m_stage_t)) u_stage_m (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(m_d), .q(m_q)
  );
  hazard_stage_reg #(.T(w_stage_t)) u_stage_w (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(w_d), .q(w_q)
  );

`ifdef HAZARD_FWD_EN
  // Stall only when no bypass can deliver the value in time; else forward
  always_comb begin
    stall    = fwd_stall(D_rs, D_tuse_rs, e_q, m_q) ||
               fwd_stall(D_rt, D_tuse_rt, e_q, m_q);
    D_rs_sel = d_sel(D_rs, e_q, m_q, w_q);
    D_rt_sel = d_sel(D_rt, e_q, m_q, w_q);
    E_rs_sel = e_sel(e_q.rs, m_q, w_q);
    E_rt_sel = e_sel(e_q.rt, m_q, w_q);
    M_rt_sel = hit(m_q.rt, w_q.wa);
  end
`else
  // No bypass: wait until every pending writer of a used source retires
  always_comb begin
    stall    = blind_stall(D_rs, D_tuse_rs, e_q, m_q, w_q) ||
               blind_stall(D_rt, D_tuse_rt, e_q, m_q, w_q);
    D_rs_sel = SEL_REG;
    D_rt_sel = SEL_REG;
    E_rs_sel = ESEL_REG;
    E_rt_sel = ESEL_REG;
    M_rt_sel = 1'b0;
  end
`endif

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Reference model tracks in-flight
// instructions by age; builds with and without HAZARD_FWD_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, D_wa;
  logic [1:0]  D_tuse_rs, D_tuse_rt, D_tnew;
  logic        stall, M_rt_sel;
  logic [1:0]  D_rs_sel, D_rt_sel, E_rs_sel, E_rt_sel;
  logic [31:0] stall_cnt;

  int nchk = 0;
  int nerr = 0;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_wa(D_wa), .D_tnew(D_tnew),
    .stall(stall), .D_rs_sel(D_rs_sel), .D_rt_sel(D_rt_sel),
    .E_rs_sel(E_rs_sel), .E_rt_sel(E_rt_sel), .M_rt_sel(M_rt_sel),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // pipe[0]=E, pipe[1]=M, pipe[2]=W; tn is Tnew at E entry
  typedef struct {
    logic [4:0] wa;
    int         tn;
    logic [4:0] rs;
    logic [4:0] rt;
  } ins_t;

  ins_t    pipe[3];
  longint  m_cnt;

  function automatic int rem(int k);
    int r;
    r = pipe[k].tn - k;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit wr(int k, logic [4:0] src);
    return (src != 0) && (pipe[k].wa == src);
  endfunction

  function automatic bit src_stall(logic [4:0] src, logic [1:0] tuse);
    if (src == 0 || tuse == 3) return 0;
`ifdef HAZARD_FWD_EN
    for (int k = 0; k < 2; k++)
      if (wr(k, src) && int'(tuse) < rem(k)) return 1;
    return 0;
`else
    for (int k = 0; k < 3; k++)
      if (wr(k, src)) return 1;
    return 0;
`endif
  endfunction

  function automatic bit m_stall();
    return src_stall(D_rs, D_tuse_rs) || src_stall(D_rt, D_tuse_rt);
  endfunction

  function automatic logic [1:0] m_dsel(logic [4:0] src);
`ifdef HAZARD_FWD_EN
    for (int k = 0; k < 3; k++)
      if (wr(k, src) && (k == 2 || rem(k) == 0)) return 2'(k + 1);
`endif
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_esel(logic [4:0] src);
`ifdef HAZARD_FWD_EN
    if (wr(1, src) && rem(1) == 0) return 2'd1;
    if (wr(2, src)) return 2'd2;
`endif
    return 2'd0;
  endfunction

  function automatic logic m_mrt();
`ifdef HAZARD_FWD_EN
    return wr(2, pipe[1].rt);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) pipe[k] = '{wa: 0, tn: 0, rs: 0, rt: 0};
    m_cnt = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("stall",     32'(stall),     32'(m_stall()));
    chk("D_rs_sel",  32'(D_rs_sel),  32'(m_dsel(D_rs)));
    chk("D_rt_sel",  32'(D_rt_sel),  32'(m_dsel(D_rt)));
    chk("E_rs_sel",  32'(E_rs_sel),  32'(m_esel(pipe[0].rs)));
    chk("E_rt_sel",  32'(E_rt_sel),  32'(m_esel(pipe[0].rt)));
    chk("M_rt_sel",  32'(M_rt_sel),  32'(m_mrt()));
    chk("stall_cnt", stall_cnt,      32'(m_cnt));
  endtask

  // Apply D inputs mid-cycle, then compare against the model
  task automatic drive(input logic [4:0] rs, input logic [1:0] tr,
                       input logic [4:0] rt, input logic [1:0] tt,
                       input logic [4:0] wa, input logic [1:0] tn,
                       input logic rst);
    @(negedge clk);
    D_rs = rs; D_tuse_rs = tr; D_rt = rt; D_tuse_rt = tt;
    D_wa = wa; D_tnew = tn; reset = rst;
    #1;
    chk_all();
  endtask

  // Clock edge: advance the model exactly as the pipeline moves
  task automatic tick();
    bit   s, r;
    ins_t nw;
    s  = m_stall();
    r  = reset;
    nw = '{wa: D_wa, tn: int'(D_tnew), rs: D_rs, rt: D_rt};
    @(posedge clk);
    if (r) model_clear();
    else begin
      if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = s ? '{wa: 0, tn: 0, rs: 0, rt: 0} : nw;
    end
  endtask

  task automatic do_reset();
    drive(0, 3, 0, 3, 0, 0, 1'b1);
    tick();
  endtask

  task automatic chk_zero_sels(input string tag);
    chk(tag, {23'd0, D_rs_sel, D_rt_sel, E_rs_sel, E_rt_sel, M_rt_sel}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    D_rs = 0; D_rt = 0; D_wa = 0;
    D_tuse_rs = 3; D_tuse_rt = 3; D_tnew = 0;
    model_clear();
    repeat (2) @(posedge clk);

    // Reset state
    drive(0, 3, 0, 3, 0, 0, 1'b0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cnt", stall_cnt, 0);
    chk_zero_sels("rst_sels");

`ifdef HAZARD_FWD_EN
    // Load-use: lw $8 then consumer at D
    do_reset();
    drive(0, 3, 0, 3, 8, 2, 1'b0); tick();
    drive(8, 0, 0, 3, 0, 0, 1'b0); chk("lu_stall1", 32'(stall), 1); tick();
    drive(8, 0, 0, 3, 0, 0, 1'b0); chk("lu_stall2", 32'(stall), 1); tick();
    drive(8, 0, 0, 3, 0, 0, 1'b0);
    chk("lu_stall3", 32'(stall), 0);
    chk("lu_dsel", 32'(D_rs_sel), 3);
    chk("lu_cnt", stall_cnt, 2);
    tick();

    // ALU chain: addu $3 then consumer at E
    do_reset();
    drive(0, 3, 0, 3, 3, 1, 1'b0); tick();
    drive(3, 1, 0, 3, 0, 0, 1'b0); chk("alu_stall", 32'(stall), 0); tick();
    drive(0, 3, 0, 3, 0, 0, 1'b0); chk("alu_esel", 32'(E_rs_sel), 1); tick();

    // Zero register never hazards
    do_reset();
    drive(0, 3, 0, 3, 0, 2, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    chk("zero_stall", 32'(stall), 0);
    chk_zero_sels("zero_sels");
    tick();

    // Priority M over W
    do_reset();
    drive(0, 3, 0, 3, 5, 0, 1'b0); tick();
    drive(0, 3, 0, 3, 5, 1, 1'b0); tick();
    drive(5, 3, 0, 3, 0, 0, 1'b0); tick();
    drive(0, 3, 0, 3, 0, 0, 1'b0); chk("prio_m", 32'(E_rs_sel), 1); tick();
    do_reset();
    drive(0, 3, 0, 3, 5, 0, 1'b0); tick();
    drive(0, 3, 0, 3, 6, 1, 1'b0); tick();
    drive(5, 3, 0, 3, 0, 0, 1'b0); tick();
    drive(0, 3, 0, 3, 0, 0, 1'b0); chk("prio_w", 32'(E_rs_sel), 2); tick();

    // Reset while stalled on lw $8
    do_reset();
    drive(0, 3, 0, 3, 8, 2, 1'b0); tick();
    drive(8, 0, 0, 3, 0, 0, 1'b0); chk("rms_pre", 32'(stall), 1); tick();
    drive(8, 0, 0, 3, 0, 0, 1'b1); tick();
    drive(8, 0, 0, 3, 0, 0, 1'b0);
    chk("rms_stall", 32'(stall), 0);
    chk("rms_cnt", stall_cnt, 0);
    chk_zero_sels("rms_sels");
    tick();
`else
    // No forwarding: addu $3 then consumer stalls until it retires
    do_reset();
    drive(0, 3, 0, 3, 3, 1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(3, 1, 0, 3, 0, 0, 1'b0);
      chk("nf_stall", 32'(stall), 1);
      chk_zero_sels("nf_sels");
      tick();
    end
    drive(3, 1, 0, 3, 0, 0, 1'b0);
    chk("nf_release", 32'(stall), 0);
    chk("nf_cnt", stall_cnt, 3);
    chk_zero_sels("nf_sels_end");
    tick();
`endif

    // Randomized traffic on a small register set to provoke hazards
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
            1'($urandom_range(0, 39) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports (clock and reset first); one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- D_rs, D_rt  in  5 each  source register numbers of the instruction in D
- D_tuse_rs, D_tuse_rt  in  2 each  Tuse: 0=D, 1=E, 2=M, 3=unused
- D_wa  in  5  destination register of the instruction in D; 0 means none
- D_tnew  in  2  Tnew at E entry: 0=jal/link, 1=ALU, 2=load
- stall  out  1  freeze PC and F/D, insert bubble into E
- D_rs_sel, D_rt_sel  out  2 each  D compare operands: 0=reg, 1=E, 2=M, 3=W
- E_rs_sel, E_rt_sel  out  2 each  ALU operands: 0=reg, 1=M, 2=W
- M_rt_sel  out  1  store data: 0=reg, 1=W
- stall_cnt  out  32  stalled-cycle counter

Function
REQ-002 The block SHALL hold a scoreboard of three stages:
- E: wa, tnew, rs, rt
- M: wa, tnew, rt
- W: wa
REQ-003 Each clock edge SHALL advance the scoreboard as follows:
- E loads D_wa/D_tnew/D_rs/D_rt when stall=0, and a bubble (all fields 0) when stall=1.
- M loads E with tnew = max(E_tnew-1, 0).
- W loads M_wa.
REQ-004 stall SHALL be combinational and equal 1 iff, for src in {rs, rt} with D_src!=0:
- E_wa==D_src and D_tuse_src < E_tnew, or
- M_wa==D_src and D_tuse_src < M_tnew.
REQ-005 D_src_sel SHALL use the first matching condition in this order; otherwise it is 0:
- 1 if E_wa==D_src and E_tnew==0
- 2 if M_wa==D_src and M_tnew==0
- 3 if W_wa==D_src
REQ-006 E_src_sel SHALL be 1 if M_wa==E_src and M_tnew==0, else 2 if W_wa==E_src, else 0.
REQ-007 M_rt_sel SHALL be 1 iff W_wa==M_rt.
REQ-008 A source or destination equal to 0 SHALL never match, so $0 is never forwarded and never stalls.
REQ-009 Forwarding priority SHALL be youngest producer first: E over M over W.
REQ-010 A D_tuse value of 3 SHALL never cause a stall.
REQ-011 stall_cnt SHALL increment by 1 in every cycle with stall=1 and saturate at 0xFFFFFFFF.
REQ-012 All select outputs SHALL be combinational from the current scoreboard state and D inputs, with zero latency.

Reset
REQ-013 While reset=1 at a clock edge, all scoreboard fields SHALL become 0 and stall_cnt SHALL become 0.
REQ-014 In the cycle after reset, stall SHALL be 0 and all selects SHALL be 0 unless the current D inputs match.
REQ-015 A reset asserted mid-stall SHALL discard the pending producer with no residual stall.

Configuration
REQ-016 With HAZARD_FWD_EN defined, the behaviour SHALL be REQ-004 to REQ-007.
REQ-017 With HAZARD_FWD_EN undefined, the block SHALL have no forwarding:
- All *_sel outputs are tied to 0.
- stall=1 iff D_src!=0, D_tuse_src!=3, and D_src matches E_wa, M_wa or W_wa, regardless of tnew.

Structure
REQ-018 A shared package hazard_pkg SHALL hold:
- Tuse encodings (TUSE_D, TUSE_E, TUSE_M, TUSE_NONE)
- Tnew encodings
- select encodings (SEL_REG, SEL_E, SEL_M, SEL_W)
REQ-019 One sub-module, hazard_stage_reg, SHALL implement a single scoreboard stage register with synchronous clear and a bubble input; it is instantiated for E, M and W.

Verification
REQ-020 Load-use, forwarding enabled:
- Stimulus: lw $8 enters E (D_tnew=2); the D instruction has D_rs=8, D_tuse_rs=0.
- Required: stall=1 for 2 cycles, then stall=0 with D_rs_sel=3; stall_cnt=2.
REQ-021 ALU chain:
- Stimulus: addu writing $3 (tnew=1) is followed by a D instruction with D_rs=3, D_tuse_rs=1.
- Required: no stall, and the next cycle shows E_rs_sel=1.
REQ-022 Zero register:
- Stimulus: D_wa=0 producer, followed by D_rs=0, D_tuse_rs=0.
- Required: stall=0 and all selects 0.
REQ-023 Priority:
- Stimulus: M_wa=W_wa=5, M_tnew=0, E_rs=5.
- Required: E_rs_sel=1; with M_wa changed to 6, E_rs_sel=2.
REQ-024 Reset mid-stall:
- Stimulus: assert reset while a lw to $8 is in E and D uses $8.
- Required: the next cycle has stall=0, stall_cnt=0 and all selects 0.
REQ-025 Forwarding disabled:
- Stimulus: HAZARD_FWD_EN undefined; addu writing $3 followed by D_rs=3, D_tuse_rs=1.
- Required: stall=1 for 3 cycles, then stall=0; selects remain 0 throughout.
